// File: rtl/scs8hd_exer_pkg.sv
// Shared types, constants and the expected-value function for the o311ai cell exerciser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   exer_state_e    - exerciser FSM states
//   VEC_W, NUM_VEC  - cell input vector width and count
//   LAST_VEC        - index of the final vector of a run
//   SETTLE_W        - width of the settle down-counter
//   o311ai_expect() - golden Y for a given input vector
package scs8hd_exer_pkg;

    localparam int VEC_W    = 5;
    localparam int NUM_VEC  = 32;
    localparam int SETTLE_W = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } exer_state_e;

    // Vector layout is {C1,B1,A3,A2,A1}; Y = !((A1|A2|A3) & B1 & C1).
    function automatic logic o311ai_expect(input logic [VEC_W-1:0] vec);
        return ~((vec[0] | vec[1] | vec[2]) & vec[3] & vec[4]);
    endfunction

endpackage

// File: rtl/scs8hd_exer_settle_ctr.sv
// Loadable down-counter with terminal-count flag, used to time cell settle windows.
// Latency: load/decrement take effect at the next clock edge; tc_o is a decode of the count register.
// Backpressure: none; decrement stops at zero instead of wrapping.
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_n_i     - asynchronous active-low reset (count returns to 0)
//   load_i      - load load_val_i into the counter (has priority over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement by one when not already zero
//   tc_o        - count is zero
module scs8hd_exer_settle_ctr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/scs8hd_o311ai_exerciser.sv
// Walks all 32 input vectors of an o311ai cell, samples Y after a settle window and counts mismatches.
// Latency: a run takes 32*(SETTLE_CYCLES+1) cycles from the accepting edge to DONE; all outputs registered.
// Backpressure: START is ignored while BUSY; no request queuing.
//
// Ports:
//   CLK, RESETB          - clock (rising edge) and asynchronous active-low reset
//   START                - run request, accepted in IDLE or DONE
//   Y_IN                 - Y output of the cell under test
//   A1/A2/A3/B1/C1_OUT   - cell input drives, equal to the current vector {C1,B1,A3,A2,A1}
//   BUSY                 - run in progress
//   DONE                 - run complete, held until the next accepted START
//   PASS                 - no mismatches in the completed run (0 unless DONE)
//   ERR_CNT              - saturating mismatch count
//   FAIL_VLD, FAIL_VEC   - first failing vector of the run; present only when
//                          SCS8HD_EXER_FIRST_FAIL_EN is defined
module scs8hd_o311ai_exerciser
    import scs8hd_exer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 6
) (
    input  logic                 CLK,
    input  logic                 RESETB,
    input  logic                 START,
    input  logic                 Y_IN,
    output logic                 A1_OUT,
    output logic                 A2_OUT,
    output logic                 A3_OUT,
    output logic                 B1_OUT,
    output logic                 C1_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
    output logic                 FAIL_VLD,
    output logic [VEC_W-1:0]     FAIL_VEC,
`endif
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    // The counter is loaded with SETTLE_CYCLES-1 on SETTLE entry; SETTLE exits
    // on the cycle it reads zero, giving exactly SETTLE_CYCLES cycles of hold.
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    exer_state_e          state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
    logic                 fail_vld_q, fail_vld_d;
    logic [VEC_W-1:0]     fail_vec_q, fail_vec_d;
`endif

    logic                 ctr_load;
    logic                 ctr_dec;
    logic                 ctr_tc;
    logic                 mismatch;
    logic [ERR_CNT_W-1:0] err_sampled;

    scs8hd_exer_settle_ctr #(
        .W (SETTLE_W)
    ) u_settle_ctr (
        .clk_i      (CLK),
        .rst_n_i    (RESETB),
        .load_i     (ctr_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (ctr_dec),
        .tc_o       (ctr_tc)
    );

    // Only meaningful in SAMPLE; vec_q has been held for the full settle window.
    assign mismatch    = (Y_IN != o311ai_expect(vec_q));
    assign err_sampled = (mismatch && !(&err_q)) ? (err_q + ERR_CNT_W'(1)) : err_q;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d  = ST_SETTLE;
                    vec_d    = '0;
                    err_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    ctr_load = 1'b1;
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
                    fail_vld_d = 1'b0;
                    fail_vec_d = '0;
`endif
                end
            end

            ST_SETTLE: begin
                if (ctr_tc) begin
                    state_d = ST_SAMPLE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end

            ST_SAMPLE: begin
                err_d = err_sampled;
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
                if (mismatch && !fail_vld_q) begin
                    fail_vld_d = 1'b1;
                    fail_vec_d = vec_q;
                end
`endif
                if (vec_q == LAST_VEC) begin
                    // Drives stay at the last vector while DONE is shown.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_sampled == '0);
                end else begin
                    state_d  = ST_SETTLE;
                    vec_d    = vec_q + VEC_W'(1);
                    ctr_load = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef SCS8HD_EXER_FIRST_FAIL_EN
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign FAIL_VLD = fail_vld_q;
    assign FAIL_VEC = fail_vec_q;
`endif

    assign A1_OUT  = vec_q[0];
    assign A2_OUT  = vec_q[1];
    assign A3_OUT  = vec_q[2];
    assign B1_OUT  = vec_q[3];
    assign C1_OUT  = vec_q[4];
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PASS    = pass_q;
    assign ERR_CNT = err_q;

endmodule

// File: tb/tb_scs8hd_o311ai_exerciser.sv
// Bench for the o311ai exerciser: two instances (default widths, and a 4-bit
// counter with SETTLE_CYCLES=1) driven by a modelled cell whose Y can be
// golden, stuck, inverted or randomly corrupted per vector.
module tb_scs8hd_o311ai_exerciser;

    localparam int S0 = 2;
    localparam int W0 = 6;
    localparam int S1 = 1;
    localparam int W1 = 4;

    logic CLK    = 1'b0;
    logic RESETB = 1'b0;
    logic START  = 1'b0;

    int          y_mode = 0;
    logic [31:0] y_mask = '0;

    logic a1, a2, a3, b1, c1, busy, done, pass, y0;
    logic [W0-1:0] err;
    logic p1, p2, p3, q1, r1, busy4, done4, pass4, y1;
    logic [W1-1:0] err4;
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
    logic       fvld, fvld4;
    logic [4:0] fvec, fvec4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    // Cell under test: mode 0 golden, 1 stuck-at-1, 2 stuck-at-0, 3 inverted, 4 golden xor per-vector mask.
    function automatic logic cell_y(input int mode, input logic [31:0] mask, input logic [4:0] v);
        logic g;
        g = ~((v[0] | v[1] | v[2]) & v[3] & v[4]);
        case (mode)
            0:       return g;
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ~g;
            default: return g ^ mask[v];
        endcase
    endfunction

    assign y0 = cell_y(y_mode, y_mask, {c1, b1, a3, a2, a1});
    assign y1 = cell_y(y_mode, y_mask, {r1, q1, p3, p2, p1});

    scs8hd_o311ai_exerciser #(.SETTLE_CYCLES(S0), .ERR_CNT_W(W0)) dut (
        .CLK(CLK), .RESETB(RESETB), .START(START), .Y_IN(y0),
        .A1_OUT(a1), .A2_OUT(a2), .A3_OUT(a3), .B1_OUT(b1), .C1_OUT(c1),
        .BUSY(busy), .DONE(done), .PASS(pass),
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
        .FAIL_VLD(fvld), .FAIL_VEC(fvec),
`endif
        .ERR_CNT(err)
    );

    scs8hd_o311ai_exerciser #(.SETTLE_CYCLES(S1), .ERR_CNT_W(W1)) dut4 (
        .CLK(CLK), .RESETB(RESETB), .START(START), .Y_IN(y1),
        .A1_OUT(p1), .A2_OUT(p2), .A3_OUT(p3), .B1_OUT(q1), .C1_OUT(r1),
        .BUSY(busy4), .DONE(done4), .PASS(pass4),
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
        .FAIL_VLD(fvld4), .FAIL_VEC(fvec4),
`endif
        .ERR_CNT(err4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: a vector expects Y=0 exactly when its index is 25..31.
    task automatic model(input int mode, input logic [31:0] mask, output int cnt, output int first);
        logic y;
        cnt   = 0;
        first = -1;
        for (int v = 0; v < 32; v++) begin
            y = cell_y(mode, mask, 5'(v));
            if (y != ((v < 25) ? 1'b1 : 1'b0)) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/drv"},   {27'd0, c1, b1, a3, a2, a1}, 0);
        chk({tag, "/busy"},  busy, 0);
        chk({tag, "/done"},  done, 0);
        chk({tag, "/pass"},  pass, 0);
        chk({tag, "/err"},   err, 0);
        chk({tag, "/drv4"},  {27'd0, r1, q1, p3, p2, p1}, 0);
        chk({tag, "/busy4"}, busy4, 0);
        chk({tag, "/done4"}, done4, 0);
        chk({tag, "/err4"},  err4, 0);
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
        chk({tag, "/fvld"},  fvld, 0);
        chk({tag, "/fvec"},  fvec, 0);
`endif
    endtask

    task automatic do_run(input int mode, input logic [31:0] mask, input bit restarts,
                          input bit rst_mid, input string tag);
        int cnt, first, done_at, done_at4, busy_n, busy_n4, vec_bad;
        bit aborted;
        model(mode, mask, cnt, first);
        y_mode   = mode;
        y_mask   = mask;
        done_at  = -1;
        done_at4 = -1;
        busy_n   = 0;
        busy_n4  = 0;
        vec_bad  = 0;
        aborted  = 0;

        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        chk({tag, "/acc_busy"}, busy, 1);
        chk({tag, "/acc_done"}, done, 0);
        chk({tag, "/acc_pass"}, pass, 0);
        chk({tag, "/acc_err"},  err, 0);
        chk({tag, "/acc_vec"},  {27'd0, c1, b1, a3, a2, a1}, 0);
        chk({tag, "/acc_done4"}, done4, 0);
        if (busy)  busy_n++;
        if (busy4) busy_n4++;

        for (int k = 1; k <= 300; k++) begin
            START = restarts && (k == 10 || k == 50);
            if (rst_mid && k == 40) begin
                #4 RESETB = 1'b0;
                #1 chk_all_zero({tag, "/midrst"});
                #2 RESETB = 1'b1;
                aborted = 1;
                break;
            end
            @(posedge CLK); #1;
            if (done_at < 0) begin
                if (done) done_at = k;
                else begin
                    if (busy) busy_n++;
                    if ({c1, b1, a3, a2, a1} != 5'(k / (S0 + 1))) vec_bad++;
                end
            end
            if (done_at4 < 0) begin
                if (done4) done_at4 = k;
                else begin
                    if (busy4) busy_n4++;
                    if ({r1, q1, p3, p2, p1} != 5'(k / (S1 + 1))) vec_bad++;
                end
            end
            if (done_at >= 0 && done_at4 >= 0) break;
        end
        START = 1'b0;

        if (!aborted) begin
            chk({tag, "/done_at"},  done_at,  32 * (S0 + 1));
            chk({tag, "/done_at4"}, done_at4, 32 * (S1 + 1));
            chk({tag, "/busy_n"},   busy_n,   32 * (S0 + 1));
            chk({tag, "/busy_n4"},  busy_n4,  32 * (S1 + 1));
            chk({tag, "/vec_seq"},  vec_bad,  0);
            chk({tag, "/busy_end"}, busy, 0);
            chk({tag, "/drv_end"},  {27'd0, c1, b1, a3, a2, a1}, 31);
            chk({tag, "/err"},      err,  (cnt > 63) ? 63 : cnt);
            chk({tag, "/pass"},     pass, (cnt == 0) ? 1 : 0);
            chk({tag, "/err4"},     err4, (cnt > 15) ? 15 : cnt);
            chk({tag, "/pass4"},    pass4, (cnt == 0) ? 1 : 0);
`ifdef SCS8HD_EXER_FIRST_FAIL_EN
            chk({tag, "/fvld"},  fvld, (first >= 0) ? 1 : 0);
            chk({tag, "/fvec"},  fvec, (first >= 0) ? first : 0);
            chk({tag, "/fvec4"}, fvec4, (first >= 0) ? first : 0);
`endif
        end
    endtask

    initial begin
        RESETB = 1'b0;
        START  = 1'b0;
        repeat (3) @(posedge CLK);
        #1 chk_all_zero("reset");
        RESETB = 1'b1;

        do_run(0, 32'd0, 0, 0, "golden");
        do_run(1, 32'd0, 0, 0, "stuck1");
        do_run(0, 32'd0, 0, 0, "after_fail");
        do_run(2, 32'd0, 0, 0, "stuck0");
        do_run(3, 32'd0, 0, 0, "invert");
        do_run(0, 32'd0, 1, 0, "restart_ign");
        do_run(0, 32'd0, 0, 1, "rst_mid");
        #1 chk_all_zero("post_rst_idle");
        do_run(0, 32'd0, 0, 0, "post_rst");
        for (int i = 0; i < 3; i++) begin
            do_run(4, $urandom(), 1'($urandom_range(0, 1)), 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
